// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: feature switches, default widths, FSM states.
package reg_file_mp_pkg;

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;

  // Defaults track the CPU word length and register-address width.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: enable gating, write-to-read bypass, optional zero-register masking.
// Latency 1 cycle; output held at zero while the array is being cleared.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = DISABLE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_arr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_rd_data;

  // Zero-register check precedes the bypass so a write to entry 0 never leaks through.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_rd_data <= '0;
    end else if (!i_rd_en) begin
      r_rd_data <= '0;
    end else if (ZERO_REG && (i_rd_addr == '0)) begin
      r_rd_data <= '0;
    end else if (i_we && (i_wr_addr == i_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= i_arr_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardware clear after reset and same-cycle write bypass.
// Reads are registered (1 cycle); define REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = ENABLE;
`else
  localparam bit ZERO_REG_EN = DISABLE;
`endif

  state_t             r_state;
  logic [ADDR_W-1:0]  r_clr_ptr;
  logic               r_busy;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_run;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (&r_clr_ptr) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // The clear sweep owns the single write port until it finishes; reset drops any write.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = i_wr_addr;
    w_mem_wdata = i_wr_data;
    if (i_rst) begin
      w_mem_we = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_ptr;
      w_mem_wdata = '0;
    end else begin
      w_mem_we = i_we && !(ZERO_REG_EN && (i_wr_addr == '0));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_run  = (r_state == ST_RUN);
  assign o_busy = r_busy;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_arr_data;

    assign w_addr     = i_rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_arr_data = r_mem[w_addr];

    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG_EN)
    ) u_rd_port (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_run      (w_run),
      .i_rd_en    (i_rd_en[gi]),
      .i_rd_addr  (w_addr),
      .i_we       (i_we),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .i_arr_data (w_arr_data),
      .o_rd_data  (o_rd_data[gi*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus random traffic against a spec-level model.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .i_we      (we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_busy    (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict outputs from the spec rules, advance the model, then compare.
  task automatic tick();
    logic [DW-1:0] e [NR];
    logic          eb;
    logic [AW-1:0] a;
    if (rst) begin
      eb = 1'b1;
      m_left = DEPTH;
      for (int p = 0; p < NR; p++) e[p] = '0;
    end else if (m_left > 0) begin
      for (int p = 0; p < NR; p++) e[p] = '0;
      m_left--;
      eb = (m_left != 0);
      if (m_left == 0) for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    end else begin
      eb = 1'b0;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        if (!rd_en[p])                  e[p] = '0;
        else if (ZERO && a == 0)        e[p] = '0;
        else if (we && wr_addr == a)    e[p] = wr_data;
        else                            e[p] = m_mem[a];
      end
      if (we && !(ZERO && wr_addr == 0)) m_mem[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) chk($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], e[p]);
    chk("busy", {31'b0, busy}, {31'b0, eb});
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
    chk(tag, n, 32);
  endtask

  initial begin
    logic [DW-1:0] zexp;
    rst = 1'b1; rd_en = '0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;

    tick();
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_rd", rd_data[31:0] | rd_data[63:32], 32'd0);

    // Writes and reads attempted throughout the clear must have no effect.
    rst = 1'b0;
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    count_clear("clear_len");
    we = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(DEPTH - 1 - a), 5'(a)};
      tick();
      chk("post_clear", rd_data[31:0] | rd_data[63:32], 32'd0);
    end

    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_en = 2'b00;
    tick();
    we = 1'b0; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    chk("wr_rd_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("wr_rd_p1", rd_data[63:32], 32'hDEADBEEF);

    rd_en = 2'b01;
    tick();
    chk("rd_dis_p1", rd_data[63:32], 32'd0);
    chk("rd_en_p0", rd_data[31:0], 32'hDEADBEEF);

    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111; rd_en = 2'b00;
    tick();
    wr_data = 32'h22222222; rd_en = 2'b01; rd_addr = {5'd5, 5'd7};
    tick();
    chk("bypass", rd_data[31:0], 32'h22222222);
    we = 1'b0;
    tick();
    chk("after_bypass", rd_data[31:0], 32'h22222222);

    zexp = ZERO ? 32'd0 : 32'h12345678;
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    chk("zero_same", rd_data[31:0], zexp);
    chk("zero_same_p1", rd_data[63:32], zexp);
    we = 1'b0;
    tick();
    chk("zero_later", rd_data[31:0], zexp);

    // Random traffic with frequent read/write address collisions and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      we      = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      rd_en   = 2'($urandom_range(0, 3));
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, DEPTH - 1));
      tick();
    end

    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("midclear_len");

    rd_en = 2'b11;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(a), 5'(a)};
      tick();
      chk("reclear", rd_data[31:0] | rd_data[63:32], 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
